// File: rtl/mux_41_arb_if.sv
// mux_41_arb_if: request/release handshake and grant/select outputs between source agents and the arbiter.
interface mux_41_arb_if;
  logic [3:0] req;
  logic       done;
  logic [1:0] s;
  logic [3:0] gnt;
  logic       busy;
  modport master (output req, done, input s, gnt, busy);
  modport slave  (input req, done, output s, gnt, busy);
endinterface

// File: rtl/mux_41_arb.sv
// mux_41_arb: round-robin arbiter owning the 4:1 mux select, with hold-limit preemption.
module mux_41_arb #(
  parameter int HOLD_MAX = 8
) (
  input  logic         clk,
  input  logic         rst,
  mux_41_arb_if.slave  bus
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [7:0] HM = 8'(HOLD_MAX);
  state_t     r_state, w_state_n;
  logic [1:0] r_owner, w_owner_n, r_ptr, w_ptr_n, r_s, w_s_n, w_win, w_idx;
  logic [3:0] r_gnt, w_gnt_n, w_own_oh, w_cand;
  logic [7:0] r_hold, w_hold_n;
  logic       w_pre, w_rel, w_found;
  assign bus.s    = r_s;
  assign bus.gnt  = r_gnt;
  assign bus.busy = r_state == GRANT;
  assign w_own_oh = 4'b0001 << r_owner;
  assign w_pre    = r_hold >= HM && |(bus.req & ~w_own_oh);
  assign w_rel    = bus.done || !bus.req[r_owner] || w_pre;
  // a preempted owner is excluded from the handover so it cannot win back immediately
  assign w_cand   = (r_state == GRANT && w_pre) ? bus.req & ~w_own_oh : bus.req;
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_idx   = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      w_idx = r_ptr + 2'(k);
      if (w_cand[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end
  always_comb begin
    w_state_n = r_state;
    w_owner_n = r_owner;
    w_ptr_n   = r_ptr;
    w_s_n     = r_s;
    w_gnt_n   = r_gnt;
    w_hold_n  = (r_state == GRANT && r_hold != 8'hff) ? r_hold + 8'd1 : r_hold;
    if (r_state == IDLE || w_rel) begin
      w_state_n = w_found ? GRANT : IDLE;
      w_gnt_n   = w_found ? 4'b0001 << w_win : 4'b0000;
      if (w_found) begin
        w_owner_n = w_win;
        w_s_n     = w_win;
        w_ptr_n   = w_win + 2'd1;
        w_hold_n  = 8'd1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_s     <= '0;
      r_gnt   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_n;
      r_owner <= w_owner_n;
      r_ptr   <= w_ptr_n;
      r_s     <= w_s_n;
      r_gnt   <= w_gnt_n;
      r_hold  <= w_hold_n;
    end
  end
endmodule

// File: tb/tb_mux_41_arb.sv
// tb_mux_41_arb: directed test-plan steps plus random traffic checked against a behavioural arbiter model.
module tb_mux_41_arb;
  localparam int HOLD = 8;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  bit   m_busy;
  int   m_owner, m_ptr, m_hold, m_s;
  mux_41_arb_if bus ();
  mux_41_arb #(.HOLD_MAX(HOLD)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model(input bit r, input logic [3:0] q, input bit d);
    logic [3:0] cand;
    bit rel;
    int w;
    if (r) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_hold = 0; m_s = 0;
      return;
    end
    cand = q;
    rel  = 0;
    if (m_busy) begin
      if (d || !q[m_owner]) rel = 1;
      else if (m_hold >= HOLD && (q & ~(4'b1 << m_owner)) != 0) begin
        rel = 1;
        cand[m_owner] = 1'b0;
      end
      if (!rel) m_hold = (m_hold + 1 > 255) ? 255 : m_hold + 1;
    end
    if (!m_busy || rel) begin
      w = -1;
      for (int k = 0; k < 4; k++)
        if (w < 0 && cand[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
      if (w >= 0) begin
        m_busy = 1; m_owner = w; m_s = w; m_hold = 1; m_ptr = (w + 1) % 4;
      end else m_busy = 0;
    end
  endtask
  task automatic cyc(input bit r, input logic [3:0] q, input bit d);
    rst = r; bus.req = q; bus.done = d;
    @(posedge clk);
    model(r, q, d);
    #1;
    chk("model_gnt", int'(bus.gnt), m_busy ? (1 << m_owner) : 0);
    chk("model_s", int'(bus.s), m_s);
    chk("model_busy", int'(bus.busy), int'(m_busy));
  endtask
  initial begin
    m_busy = 0; m_owner = 0; m_ptr = 0; m_hold = 0; m_s = 0;
    repeat (3) cyc(1, 4'b1111, 0);
    chk("rst_gnt", int'(bus.gnt), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_s", int'(bus.s), 0);
    cyc(0, 4'b1111, 0);
    chk("post_rst_gnt", int'(bus.gnt), 4'b0001);
    cyc(0, 4'b0100, 0);
    chk("single_gnt", int'(bus.gnt), 4'b0100);
    chk("single_s", int'(bus.s), 2);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 4'b0100, 0);
      chk("single_hold", int'(bus.gnt), 4'b0100);
    end
    cyc(0, 4'b0000, 0);
    chk("single_drop", int'(bus.gnt), 0);
    cyc(1, 4'b0000, 0);
    cyc(0, 4'b1111, 0);
    chk("rr_first", int'(bus.s), 0);
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 4'b1111, 1);
      chk("rr_s", int'(bus.s), i % 4);
      chk("rr_busy", int'(bus.busy), 1);
    end
    cyc(1, 4'b0000, 0);
    for (int i = 0; i < 24; i++) begin
      cyc(0, 4'b0011, 0);
      chk("preempt_gnt", int'(bus.gnt), ((i / 8) % 2) ? 4'b0010 : 4'b0001);
    end
    cyc(1, 4'b0000, 0);
    cyc(0, 4'b0100, 0);
    chk("simul_own2", int'(bus.gnt), 4'b0100);
    cyc(0, 4'b0101, 1);
    chk("simul_gnt", int'(bus.gnt), 4'b0001);
    chk("simul_s", int'(bus.s), 0);
    cyc(1, 4'b0000, 0);
    cyc(0, 4'b1000, 0);
    chk("mid_own3", int'(bus.s), 3);
    cyc(1, 4'b1000, 0);
    chk("mid_rst_gnt", int'(bus.gnt), 0);
    chk("mid_rst_s", int'(bus.s), 0);
    cyc(0, 4'b1010, 0);
    chk("mid_next", int'(bus.gnt), 4'b0010);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(63) == 0, 4'($urandom_range(15)), $urandom_range(3) == 0);
    for (int i = 0; i < 60; i++)
      cyc(0, 4'b1111, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
